// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-to-8 decoder select across the enabled channels of a captured mask,
// holding EN high for a dwell period and low for a blanking period on each channel.
module scan_sequencer #(
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Continuous,
   input  logic [7:0]         Mask,
   input  logic [DWELL_W-1:0] Dwell,
   input  logic [BLANK_W-1:0] Blank,
   output logic [2:0]         W,
   output logic               EN,
   output logic               Busy,
   output logic               Done,
   output logic [7:0]         FrameCount
);
   localparam int CW = DWELL_W > BLANK_W ? DWELL_W : BLANK_W;
   typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
   state_t state_q, state_d;
   logic [2:0] w_q, w_d;
   logic en_q, en_d, done_q, done_d, cont_q, cont_d, adv;
   logic [7:0] fc_q, fc_d, mask_q, mask_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [BLANK_W-1:0] blank_q, blank_d;
   logic [3:0] nxt;
   function automatic logic [2:0] lowest(input logic [7:0] m);
      lowest = 3'd0;
      for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
   endfunction
   // {found, index} of the nearest set mask bit above w
   function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] w);
      next_above = 4'd0;
      for (int i = 7; i >= 0; i--) if (m[i] && i > int'(w)) next_above = {1'b1, 3'(i)};
   endfunction
   // counter holds remaining cycles minus one; a zero dwell still gives one EN cycle
   function automatic logic [CW-1:0] dwell_load(input logic [DWELL_W-1:0] d);
      dwell_load = (d == '0) ? '0 : CW'(d - 1'b1);
   endfunction
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      en_d    = en_q;
      done_d  = 1'b0;
      fc_d    = fc_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      blank_d = blank_q;
      cont_d  = cont_q;
      adv     = 1'b0;
      nxt     = next_above(mask_q, w_q);
      if (state_q == IDLE) begin
         if (Start && !Stop && Mask != '0) begin
            mask_d  = Mask;
            dwell_d = Dwell;
            blank_d = Blank;
            cont_d  = Continuous;
            w_d     = lowest(Mask);
            en_d    = 1'b1;
            cnt_d   = dwell_load(Dwell);
            state_d = DWELL;
         end
      end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (state_q == DWELL && blank_q != '0) begin
         state_d = BLANK;
         en_d    = 1'b0;
         cnt_d   = CW'(blank_q - 1'b1);
      end else adv = 1'b1;
      if (adv) begin
         cnt_d = dwell_load(dwell_q);
         if (nxt[3]) begin
            w_d     = nxt[2:0];
            en_d    = 1'b1;
            state_d = DWELL;
         end else begin
            done_d  = 1'b1;
            fc_d    = fc_q + 1'b1;
            w_d     = cont_q ? lowest(mask_q) : w_q;
            en_d    = cont_q;
            state_d = cont_q ? DWELL : IDLE;
         end
      end
      // Stop overrides everything, including a coincident frame end
      if (Stop) begin
         state_d = IDLE;
         w_d     = w_q;
         en_d    = 1'b0;
         done_d  = 1'b0;
         fc_d    = fc_q;
      end
   end
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         fc_q    <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         dwell_q <= '0;
         blank_q <= '0;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         en_q    <= en_d;
         done_q  <= done_d;
         fc_q    <= fc_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         dwell_q <= dwell_d;
         blank_q <= blank_d;
         cont_q  <= cont_d;
      end
   end
   assign W          = w_q;
   assign EN         = en_q;
   assign Busy       = state_q != IDLE;
   assign Done       = done_q;
   assign FrameCount = fc_q;
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, bit width of the dwell count.
REQ-002 SHALL have parameter BLANK_W, default 4, bit width of the blank count.
REQ-003 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begin scan; sampled only in IDLE.
REQ-006 SHALL have port Stop  input  1  abort scan; synchronous; sampled in any state.
REQ-007 SHALL have port Continuous  input  1  1 = repeat frames, 0 = single frame.
REQ-008 SHALL have port Mask  input  8  channel enable; bit i = channel i is scanned.
REQ-009 SHALL have port Dwell  input  DWELL_W  EN-high cycles per channel.
REQ-010 SHALL have port Blank  input  BLANK_W  EN-low cycles after each channel.
REQ-011 SHALL have port W  output  3  channel index that drives the 3-to-8 decoder select.
REQ-012 SHALL have port EN  output  1  decoder enable.
REQ-013 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port Done  output  1  one-cycle pulse at frame completion.
REQ-015 SHALL have port FrameCount  output  8  completed-frame counter.
REQ-016 SHALL register all outputs; there SHALL be no combinational input-to-output path.

Function
REQ-017 SHALL implement the states IDLE, DWELL and BLANK.
REQ-018 In IDLE, Start=1, Stop=0 and Mask!=0 SHALL capture Mask, Dwell, Blank and Continuous into shadow registers at that edge. The same edge SHALL set W to the lowest set Mask bit, set EN=1 and enter DWELL.
REQ-019 Start with Mask==0 SHALL be ignored: the block stays in IDLE and all outputs are unchanged.
REQ-020 Start SHALL be ignored while Busy=1, and input changes while Busy=1 SHALL have no effect. Only the shadow values govern the scan, except Stop.
REQ-021 In DWELL, EN SHALL remain 1 for exactly max(shadow Dwell,1) cycles; Dwell=0 SHALL be treated as 1.
REQ-022 At the end of a DWELL, if shadow Blank!=0 the block SHALL enter BLANK with EN=0 and W held for exactly Blank cycles.
REQ-023 At the end of a DWELL, if shadow Blank==0 the block SHALL advance directly to the next channel with no EN-low cycle.
REQ-024 The next channel SHALL be the next higher set shadow Mask bit; unset channels SHALL be skipped with zero cycle cost.
REQ-025 Completion of the highest set channel (end of its DWELL, plus its BLANK if Blank!=0) SHALL end the frame.
REQ-026 At frame end the block SHALL assert Done for exactly one cycle and increment FrameCount modulo 256 (255 wraps to 0).
REQ-027 At frame end with shadow Continuous=1, the same edge SHALL restart at the lowest set shadow Mask bit in DWELL with EN=1.
REQ-028 At frame end with shadow Continuous=0, the block SHALL enter IDLE with EN=0 and W held.
REQ-029 A single-channel mask SHALL produce a one-channel frame; with Continuous=1 it SHALL dwell repeatedly on that channel.
REQ-030 Stop=1 SHALL, at the next edge, force IDLE and EN=0, with no Done pulse and no FrameCount increment.
REQ-031 If Stop and frame end coincide, Stop SHALL win.
REQ-032 If Stop and Start coincide in IDLE, Stop SHALL win and no scan SHALL start.
REQ-033 EN SHALL never be 1 while the state is IDLE.
REQ-034 W SHALL change only on an edge that enters DWELL.

Reset
REQ-035 Reset=1 SHALL immediately force IDLE, W=0, EN=0, Busy=0, Done=0, FrameCount=0 and clear all shadow registers and counters.
REQ-036 Reset asserted mid-scan SHALL take priority over all inputs; after release the block SHALL wait in IDLE for a new Start.

Verification
REQ-037 Mask=8'b1010_0101, Dwell=2, Blank=1, Continuous=0, Start pulse -> W/EN sequence 0/1,0/1,0/0,2/1,2/1,2/0,5/1,5/1,5/0,7/1,7/1,7/0; Done=1 one cycle; FrameCount=1; then IDLE.
REQ-038 Mask=8'hFF, Dwell=0, Blank=0, Continuous=1 -> W steps 0..7 once per cycle with EN constantly 1; Done pulses every 8 cycles; FrameCount increments each frame.
REQ-039 Start with Mask=0 -> Busy stays 0 and EN stays 0; a Start while Busy=1 -> sequence unchanged.
REQ-040 Stop during the DWELL of channel 2 -> next edge EN=0, Busy=0, Done=0, FrameCount unchanged; Stop coincident with Start in IDLE -> no scan starts.
REQ-041 Reset pulsed mid-BLANK -> outputs zero immediately, asynchronously to Clock; after release, IDLE persists until the next Start.
REQ-042 Continuous run with Mask=8'h80, Dwell=1, Blank=0 for 256 frames -> FrameCount wraps 255 to 0 and Done is high every cycle.
